// File: rtl/store_buffer_drain.sv
// ============================================================================
// Module   : store_buffer_drain
// Brief    : Drains committed stores from the store buffer tail into the
//            data-cache write port (valid/ready). Lane-aligns data, builds
//            byte enables, drops misaligned stores, and reports when nothing
//            is pending so a fence can complete.
//            Optional statistics counters: define STORE_DRAIN_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_buffer_drain_pkg;
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } cache_access_size_t;
endpackage

module store_buffer_drain
  import store_buffer_drain_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32   // byte-lane logic assumes exactly 4 lanes
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [ADDR_SIZE-1:0] sb_addr_i,
  input  logic [WORD_SIZE-1:0] sb_data_i,
  input  cache_access_size_t   sb_size_i,
  input  logic                 sb_empty_i,
  output logic                 sb_get_enable_o,
  input  logic                 hold_i,
  input  logic                 drain_req_i,
  output logic                 drained_o,
  output logic                 cache_wr_valid_o,
  input  logic                 cache_wr_ready_i,
  output logic [ADDR_SIZE-1:0] cache_wr_addr_o,
  output logic [WORD_SIZE-1:0] cache_wr_data_o,
  output logic [3:0]           cache_wr_be_o,
  output cache_access_size_t   cache_wr_size_o,
  output logic                 misaligned_o,
  output logic [31:0]          stores_issued_o,
  output logic [31:0]          stall_cycles_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]           r_state;
  logic [0:0]           w_state_next;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_data;
  logic [3:0]           r_be;
  cache_access_size_t   r_size;
  logic                 r_misaligned;

  logic                 w_can_pop;
  logic                 w_pop;
  logic                 w_load;
  logic [1:0]           w_off;
  logic [3:0]           w_be;
  logic [WORD_SIZE-1:0] w_data;
  logic                 w_misaligned;

  // A fence overrides hold; a new entry may be taken whenever the output
  // slot is free or is being handed to the cache this cycle. Reset gates
  // the pop so nothing leaves the buffer while the core is in reset.
  assign w_can_pop = !sb_empty_i && (!hold_i || drain_req_i);
  assign w_pop     = !reset_i && w_can_pop &&
                     ((r_state == S_IDLE) || cache_wr_ready_i);
  assign w_load    = w_pop && !w_misaligned;

  // Lane alignment, byte enables and misalignment detection for the tail entry
  always_comb begin
    w_off        = sb_addr_i[1:0];
    w_be         = 4'b1111;
    w_data       = sb_data_i;
    w_misaligned = 1'b0;
    case (sb_size_i)
      SIZE_BYTE: begin
        w_be   = 4'b0001 << w_off;
        w_data = {4{sb_data_i[7:0]}};
      end
      SIZE_HALF: begin
        w_be         = 4'b0011 << w_off;
        w_data       = {2{sb_data_i[15:0]}};
        w_misaligned = w_off[0];
      end
      // Word, and the unused encoding treated as word
      default: w_misaligned = (w_off != 2'b00);
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next state: a request is held until accepted; a misaligned pop never
  // creates a request, so it leads to IDLE once any current one finishes.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = w_load ? S_ISSUE : S_IDLE;
      S_ISSUE: if (cache_wr_ready_i) w_state_next = w_load ? S_ISSUE : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs derived from the state
  always_comb begin
    cache_wr_valid_o = (r_state == S_ISSUE);
    drained_o        = sb_empty_i && (r_state == S_IDLE);
    sb_get_enable_o  = w_pop;
  end

  // Request payload: captured only on a valid pop, otherwise frozen so the
  // cache sees a stable request until it accepts it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_addr       <= '0;
      r_data       <= '0;
      r_be         <= 4'b0000;
      r_size       <= SIZE_BYTE;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_pop && w_misaligned;
      if (w_load) begin
        r_addr <= {sb_addr_i[ADDR_SIZE-1:2], 2'b00};
        r_data <= w_data;
        r_be   <= w_be;
        r_size <= sb_size_i;
      end
    end
  end

  assign cache_wr_addr_o = r_addr;
  assign cache_wr_data_o = r_data;
  assign cache_wr_be_o   = r_be;
  assign cache_wr_size_o = r_size;
  assign misaligned_o    = r_misaligned;

`ifdef STORE_DRAIN_STATS_EN
  logic [31:0] r_stores_issued;
  logic [31:0] r_stall_cycles;

  // Accepted-request and back-pressure counters, wrapping naturally
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_stores_issued <= 32'd0;
      r_stall_cycles  <= 32'd0;
    end else if (cache_wr_valid_o) begin
      if (cache_wr_ready_i) r_stores_issued <= r_stores_issued + 32'd1;
      else                  r_stall_cycles  <= r_stall_cycles + 32'd1;
    end
  end

  assign stores_issued_o = r_stores_issued;
  assign stall_cycles_o  = r_stall_cycles;
`else
  assign stores_issued_o = 32'd0;
  assign stall_cycles_o  = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_buffer_drain.sv
// ============================================================================
// Module   : tb_store_buffer_drain
// Brief    : Self-checking bench for store_buffer_drain. A queue stands in for
//            the store buffer; a transaction-level model predicts the cache
//            request stream and fence status, and is compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_buffer_drain;
  import store_buffer_drain_pkg::*;

  logic               clk_i = 1'b0;
  logic               reset_i = 1'b1;
  logic [31:0]        sb_addr_i = '0;
  logic [31:0]        sb_data_i = '0;
  cache_access_size_t sb_size_i = SIZE_BYTE;
  logic               sb_empty_i = 1'b1;
  logic               sb_get_enable_o;
  logic               hold_i = 1'b0;
  logic               drain_req_i = 1'b0;
  logic               drained_o;
  logic               cache_wr_valid_o;
  logic               cache_wr_ready_i = 1'b1;
  logic [31:0]        cache_wr_addr_o;
  logic [31:0]        cache_wr_data_o;
  logic [3:0]         cache_wr_be_o;
  cache_access_size_t cache_wr_size_o;
  logic               misaligned_o;
  logic [31:0]        stores_issued_o;
  logic [31:0]        stall_cycles_o;

  store_buffer_drain #(.ADDR_SIZE(32), .WORD_SIZE(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .sb_addr_i(sb_addr_i), .sb_data_i(sb_data_i), .sb_size_i(sb_size_i),
    .sb_empty_i(sb_empty_i), .sb_get_enable_o(sb_get_enable_o),
    .hold_i(hold_i), .drain_req_i(drain_req_i), .drained_o(drained_o),
    .cache_wr_valid_o(cache_wr_valid_o), .cache_wr_ready_i(cache_wr_ready_i),
    .cache_wr_addr_o(cache_wr_addr_o), .cache_wr_data_o(cache_wr_data_o),
    .cache_wr_be_o(cache_wr_be_o), .cache_wr_size_o(cache_wr_size_o),
    .misaligned_o(misaligned_o),
    .stores_issued_o(stores_issued_o), .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]        addr;
    logic [31:0]        data;
    cache_access_size_t size;
  } entry_t;

  entry_t      sbq[$];
  int          tests = 0;
  int          fails = 0;
  bit          do_pop = 1'b0;
  bit          model_en = 1'b0;

  // Transaction model state
  bit                 m_pending = 1'b0;
  logic [31:0]        m_addr = '0;
  logic [31:0]        m_data = '0;
  logic [3:0]         m_be = '0;
  cache_access_size_t m_size = SIZE_BYTE;
  bit                 m_mis = 1'b0;
  logic [31:0]        m_issued = '0;
  logic [31:0]        m_stall = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the cache must see for a given store-buffer entry
  function automatic void expect_req(input entry_t e, output bit mis,
                                     output logic [31:0] a, output logic [31:0] d,
                                     output logic [3:0] be);
    int off;
    off = int'(e.addr % 4);
    a   = e.addr - 32'(off);
    case (e.size)
      SIZE_BYTE: begin mis = 1'b0;        be = 4'(2 ** off);     d = {4{e.data[7:0]}};  end
      SIZE_HALF: begin mis = (off % 2) != 0; be = 4'(3 * (2 ** off)); d = {2{e.data[15:0]}}; end
      default:   begin mis = (off != 0);  be = 4'hF;             d = e.data;            end
    endcase
  endfunction

  task automatic push(input logic [31:0] a, input logic [31:0] d, input cache_access_size_t s);
    entry_t e;
    e.addr = a; e.data = d; e.size = s;
    sbq.push_back(e);
  endtask

  // Store-buffer stand-in: retire the popped entry, then present the new tail
  always @(posedge clk_i) begin
    #1;
    if (do_pop) begin
      sbq.delete(0);
      do_pop = 1'b0;
    end
    #1;
    sb_empty_i = (sbq.size() == 0);
    if (sbq.size() != 0) begin
      sb_addr_i = sbq[0].addr;
      sb_data_i = sbq[0].data;
      sb_size_i = sbq[0].size;
    end
  end

  // Every-cycle comparison against the model, then advance the model
  always @(negedge clk_i) begin
    bit          can, pop, mis;
    logic [31:0] a, d;
    logic [3:0]  be;
    if (model_en) begin
      check("valid", cache_wr_valid_o, m_pending);
      if (m_pending) begin
        check("addr", cache_wr_addr_o, m_addr);
        check("data", cache_wr_data_o, m_data);
        check("be",   cache_wr_be_o,   m_be);
        check("size", cache_wr_size_o, m_size);
      end
      check("drained", drained_o, (sbq.size() == 0) && !m_pending);
      check("misaligned", misaligned_o, m_mis);
`ifdef STORE_DRAIN_STATS_EN
      check("stores_issued", stores_issued_o, m_issued);
      check("stall_cycles",  stall_cycles_o,  m_stall);
`else
      check("stores_issued", stores_issued_o, 0);
      check("stall_cycles",  stall_cycles_o,  0);
`endif
      can = (sbq.size() != 0) && (!hold_i || drain_req_i);
      pop = can && (!m_pending || cache_wr_ready_i);
      check("get_enable", sb_get_enable_o, pop);
      m_mis = 1'b0;
      if (m_pending) begin
        if (cache_wr_ready_i) begin m_issued++; m_pending = 1'b0; end
        else m_stall++;
      end
      if (pop) begin
        expect_req(sbq[0], mis, a, d, be);
        if (mis) m_mis = 1'b1;
        else begin
          m_pending = 1'b1; m_addr = a; m_data = d; m_be = be; m_size = sbq[0].size;
        end
        do_pop = 1'b1;
      end
    end
  end

  // Single-store directed check with literal expectations; starts at posedge+1
  task automatic single_store(input string nm, input logic [31:0] a, input logic [31:0] d,
                              input cache_access_size_t s, input logic [31:0] ea,
                              input logic [31:0] ed, input logic [3:0] ebe);
    push(a, d, s);
    @(negedge clk_i); check({nm, "_pop"}, sb_get_enable_o, 1);
    @(negedge clk_i);
    check({nm, "_valid"}, cache_wr_valid_o, 1);
    check({nm, "_addr"},  cache_wr_addr_o, ea);
    check({nm, "_data"},  cache_wr_data_o, ed);
    check({nm, "_be"},    cache_wr_be_o, ebe);
    @(negedge clk_i); check({nm, "_drained"}, drained_o, 1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    bit          mis;
    logic [31:0] a, d;
    logic [3:0]  be;
    entry_t      e;

    // Pin the model's alignment rules to hand-computed values
    e.addr = 32'h2003; e.data = 32'hA5; e.size = SIZE_BYTE;
    expect_req(e, mis, a, d, be);
    check("model_byte", {a, d}, {32'h2000, 32'hA5A5A5A5}); check("model_byte_be", be, 4'b1000);
    e.addr = 32'h2002; e.data = 32'h1234; e.size = SIZE_HALF;
    expect_req(e, mis, a, d, be);
    check("model_half", {28'd0, be, d}, {28'd0, 4'b1100, 32'h12341234});
    e.addr = 32'h3002; e.data = 32'h1; e.size = SIZE_WORD;
    expect_req(e, mis, a, d, be);
    check("model_word_mis", mis, 1);

    // Reset state
    #12;
    check("rst_valid", cache_wr_valid_o, 0);
    check("rst_be", cache_wr_be_o, 0);
    check("rst_drained", drained_o, 1);
    check("rst_get_enable", sb_get_enable_o, 0);
    @(negedge clk_i); #2 reset_i = 1'b0;
    @(posedge clk_i); #1 model_en = 1'b1;

    // Aligned stores of each size
    single_store("word", 32'h1000, 32'hDEADBEEF, SIZE_WORD, 32'h1000, 32'hDEADBEEF, 4'b1111);
    single_store("byte", 32'h2003, 32'h000000A5, SIZE_BYTE, 32'h2000, 32'hA5A5A5A5, 4'b1000);
    single_store("half", 32'h2002, 32'h00001234, SIZE_HALF, 32'h2000, 32'h12341234, 4'b1100);

    // Back-pressure: three queued stores, ready low for three valid cycles
    cache_wr_ready_i = 1'b0;
    push(32'h5000, 32'h11111111, SIZE_WORD);
    push(32'h5004, 32'h22222222, SIZE_WORD);
    push(32'h5009, 32'h00000033, SIZE_BYTE);
    repeat (4) @(posedge clk_i);
    #1 cache_wr_ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
`ifdef STORE_DRAIN_STATS_EN
    check("stats_issued", stores_issued_o, 6);
    check("stats_stall", stall_cycles_o, 3);
`else
    check("stats_issued", stores_issued_o, 0);
    check("stats_stall", stall_cycles_o, 0);
`endif

    // Hold blocks pops; a fence overrides it and drains everything
    hold_i = 1'b1;
    push(32'h6000, 32'hAAAA5555, SIZE_WORD);
    push(32'h6006, 32'h0000BEEF, SIZE_HALF);
    repeat (3) @(negedge clk_i);
    check("hold_no_pop", sb_get_enable_o, 0);
    check("hold_not_drained", drained_o, 0);
    @(posedge clk_i); #1 drain_req_i = 1'b1;
    for (int i = 0; i < 20 && !(drained_o === 1'b1 && sbq.size() == 0); i++) @(negedge clk_i);
    check("fence_drained", drained_o, 1);
    @(posedge clk_i); #1 drain_req_i = 1'b0; hold_i = 1'b0;

    // Misaligned word: popped, flagged for one cycle, never requested
    push(32'h3002, 32'hCAFEF00D, SIZE_WORD);
    @(negedge clk_i); check("mis_pop", sb_get_enable_o, 1);
    @(negedge clk_i); check("mis_pulse", misaligned_o, 1); check("mis_no_valid", cache_wr_valid_o, 0);
    @(negedge clk_i); check("mis_pulse_end", misaligned_o, 0); check("mis_no_valid2", cache_wr_valid_o, 0);
    @(posedge clk_i); #1;

    // Asynchronous reset while a request is stalled in flight
    cache_wr_ready_i = 1'b0;
    push(32'h4000, 32'h87654321, SIZE_WORD);
    @(posedge clk_i);
    @(negedge clk_i); check("pre_rst_valid", cache_wr_valid_o, 1);
    #2 model_en = 1'b0; reset_i = 1'b1;
    #1 check("async_rst_valid", cache_wr_valid_o, 0);
    check("async_rst_get_enable", sb_get_enable_o, 0);
    check("async_rst_counter", stores_issued_o, 0);
    sbq.delete();
    m_pending = 1'b0; m_mis = 1'b0; m_issued = '0; m_stall = '0;
    @(negedge clk_i); #2 reset_i = 1'b0; cache_wr_ready_i = 1'b1;
    @(posedge clk_i); #1 model_en = 1'b1;
    single_store("post_rst", 32'h7001, 32'h0000005A, SIZE_BYTE, 32'h7000, 32'h5A5A5A5A, 4'b0010);
    repeat (2) @(posedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
